nanov_reg_writer: RTL and testbench
===================================

// Module: nanov_reg_writer
// PURPOSE
//  Bit-serial write-port driver for the nanoV RV32E register file. Accepts a parallel
//  32-bit result plus destination register over a valid/ready handshake, then streams
//  it LSB-first onto the register file write interface (wr_en/data_rd, wr_next_en/data_rd_next).
//  Used for multi-cycle results (loads, CSR reads) produced in parallel form.
// PARAMETERS
//  XLEN        32  word width in bits; the bit counter is $clog2(XLEN) wide
//  RADDR_W      4  register address width (RV32E: x0..x15)
// PORTS
//  clk            in   1      clock, all logic on posedge
//  rst            in   1      synchronous reset, active-high
//  in_valid       in   1      parallel word offered
//  in_ready       out  1      writer can accept a word this cycle
//  in_data        in   XLEN   word to write
//  in_rd          in   RADDR_W destination register
//  bit0           in   1      core phase strobe: high in the cycle the write slot holds bit 0
//  wr_en          out  1      write data_rd into rd at the current bit slot
//  wr_next_en     out  1      write data_rd_next into rd at the next bit slot
//  rd             out  RADDR_W destination register for the active write
//  data_rd        out  1      current bit, in_data[k]
//  data_rd_next   out  1      lookahead bit, in_data[k+1]
//  read_through   out  1      destination forwarding allowed (high throughout SHIFT)
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse in the last SHIFT cycle (k == XLEN-1)
// BEHAVIOUR
//  - Reset: state=IDLE, counter k=0, shift reg=0, rd=0. All outputs 0, except in_ready=1.
//  - States: IDLE, ARMED, SHIFT.
//  - IDLE: in_ready=1. If in_valid: latch in_data/in_rd, go to ARMED.
//  - ARMED: in_ready=0. Wait for bit0. bit0 is sampled only in ARMED, never in the accept
//    cycle. On bit0: k<=0, go to SHIFT. The first SHIFT cycle is the cycle after bit0.
//  - SHIFT cycle k (0..XLEN-1):
//    - data_rd=word[k] with wr_en=1.
//    - data_rd_next=word[k+1] with wr_next_en=1 for k<XLEN-1.
//    - At k=XLEN-1: wr_next_en=0 and data_rd_next=0.
//    - rd holds the latched register; read_through=1.
//  - Latency: accept to the first wr_en is 2 cycles plus the wait for bit0.
//    The write occupies exactly XLEN cycles.
//  - Last cycle (k=XLEN-1): done=1 and in_ready=1.
//    - in_valid=1: latch the new word and go to ARMED (back-to-back; bit0 arrives 1 cycle later).
//    - Otherwise: go to IDLE.
//  - Outside SHIFT: wr_en, wr_next_en, data_rd, data_rd_next, read_through and done are 0.
//    rd keeps its last value.
//  - Arithmetic: k wraps only via the state change; it never counts past XLEN-1.
//    The word is stored unmodified; a shift register or an indexed mux are both acceptable.
//  - bit0 during SHIFT is ignored. The core guarantees a period of XLEN cycles.
//  - in_valid while busy (not the last cycle) is ignored. The producer must hold the
//    word until in_ready.
//  - rst mid-SHIFT: enables are low from the next cycle; the partial write is abandoned.
//    The register content is then undefined; the core is responsible for this.
// CONFIGURATION
//  NANOV_REG_WRITER_X0_DROP_EN
//   defined:   an in_rd==0 word is accepted and sequenced normally (busy, done, timing
//              unchanged). wr_en, wr_next_en and read_through are held 0 for that word.
//   undefined: an x0 write drives the enables like any other register. The register file
//              discards it.
// TESTING
//  1. Reset:
//     rst 2 cycles -> in_ready=1; busy, wr_en, wr_next_en, done = 0.
//  2. Basic write:
//     in_data=0x8000_0001, rd=5, bit0 3 cycles after accept
//     -> wr_en high 32 cycles, starting 1 cycle after bit0; rd=5.
//     -> data_rd = 1, then 30 zeros, then 1.
//     -> data_rd_next = 0 ... 1 at k=30, then 0 at k=31; wr_next_en low at k=31.
//     -> done pulses at k=31.
//  3. Back-to-back:
//     0xDEAD_BEEF to x3, then 0x1234_5678 to x7 offered at done
//     -> accepted at k=31; second SHIFT starts 1 cycle after the next bit0; no gap bits.
//  4. Busy backpressure:
//     in_valid held during SHIFT k=10 -> in_ready=0; the word is not latched until k=31.
//  5. Mid-SHIFT reset:
//     rst at k=12 -> the next cycle has wr_en=0, state IDLE, in_ready=1.
//     A later word to x1 streams correctly.
//  6. x0 write, 0xFFFF_FFFF to x0:
//     with NANOV_REG_WRITER_X0_DROP_EN -> enables stay 0; done still pulses after 32 cycles.
//     without it -> wr_en high 32 cycles with rd=0.

Source files
------------

// File: rtl/nanov_reg_writer_if.sv
// Parallel-word handshake between a result producer and the bit-serial register writer.
interface nanov_reg_writer_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_data;
  logic [RADDR_W-1:0] in_rd;

  modport master (output in_valid, output in_data, output in_rd, input in_ready);
  modport slave  (input in_valid, input in_data, input in_rd, output in_ready);
endinterface

// File: rtl/nanov_reg_writer.sv
// Streams a parallel word LSB-first onto the nanoV register-file write port, aligned to bit0.
// Optional build macro NANOV_REG_WRITER_X0_DROP_EN suppresses write enables for x0 words.
module nanov_reg_writer #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  nanov_reg_writer_if.slave  in_bus,
  input  logic               bit0,
  output logic               wr_en,
  output logic               wr_next_en,
  output logic [RADDR_W-1:0] rd,
  output logic               data_rd,
  output logic               data_rd_next,
  output logic               read_through,
  output logic               busy,
  output logic               done
);

  localparam int KW = $clog2(XLEN);
  localparam logic [KW-1:0] K_LAST = KW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t             state_reg, state_next;
  logic [KW-1:0]      k_reg, k_next;
  logic [XLEN-1:0]    word_reg, word_next;
  logic [RADDR_W-1:0] rd_reg, rd_next;
  logic               last, ready, accept, drop;

  assign last   = (state_reg == SHIFT) && (k_reg == K_LAST);
  assign ready  = (state_reg == IDLE) || last;
  assign accept = in_bus.in_valid && ready;
  assign rd     = rd_reg;

`ifdef NANOV_REG_WRITER_X0_DROP_EN
  assign drop = (rd_reg == '0);
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg    <= '0;
      word_reg <= '0;
      rd_reg   <= '0;
    end else begin
      k_reg    <= k_next;
      word_reg <= word_next;
      rd_reg   <= rd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    word_next  = word_reg;
    rd_next    = rd_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          word_next  = in_bus.in_data;
          rd_next    = in_bus.in_rd;
          state_next = ARMED;
        end
      end
      ARMED: begin
        // bit0 is only looked at here, so a strobe in the accept cycle is never seen
        if (bit0) begin
          k_next     = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          k_next = '0;
          if (accept) begin
            word_next  = in_bus.in_data;
            rd_next    = in_bus.in_rd;
            state_next = ARMED;
          end else begin
            state_next = IDLE;
          end
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_bus.in_ready = ready;
    busy            = (state_reg != IDLE);
    wr_en           = 1'b0;
    wr_next_en      = 1'b0;
    data_rd         = 1'b0;
    data_rd_next    = 1'b0;
    read_through    = 1'b0;
    done            = 1'b0;
    if (state_reg == SHIFT) begin
      wr_en        = !drop;
      data_rd      = word_reg[k_reg];
      read_through = !drop;
      done         = last;
      if (!last) begin
        wr_next_en   = !drop;
        data_rd_next = word_reg[k_reg + KW'(1)];
      end
    end
  end

endmodule

// File: tb/tb_nanov_reg_writer.sv
// Self-checking bench for nanov_reg_writer: vector table, corner sequences, random vs. timestamp model.
module tb_nanov_reg_writer;
  localparam int XLEN = 32;
  localparam int RW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit0;
  logic          wr_en, wr_next_en, data_rd, data_rd_next, read_through, busy, done;
  logic [RW-1:0] rd;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nanov_reg_writer_if #(.XLEN(XLEN), .RADDR_W(RW)) bus ();

  nanov_reg_writer #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (bus),
    .bit0         (bit0),
    .wr_en        (wr_en),
    .wr_next_en   (wr_next_en),
    .rd           (rd),
    .data_rd      (data_rd),
    .data_rd_next (data_rd_next),
    .read_through (read_through),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [31:0]   data;
    logic [RW-1:0] rd;
    int            w;           // cycles from accept to bit0
    int            exp_lat;     // cycles from accept to first wr_en, -1 if none
    int            exp_wr;
    int            exp_nxt;
    logic [31:0]   exp_stream;  // data_rd by k
    logic [31:0]   exp_nstream; // data_rd_next by k
    int            exp_done_c;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit drop_rd(input logic [RW-1:0] r);
`ifdef NANOV_REG_WRITER_X0_DROP_EN
    return (r == '0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic [RW-1:0] r,
                     input logic b, input logic rs);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_rd    = r;
    bit0         = b;
    rst          = rs;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          first = -1;
    int          nwr = 0;
    int          nnx = 0;
    int          ndone = 0;
    int          done_c = -1;
    int          waited = 0;
    logic [31:0] s = '0;
    logic [31:0] ns = '0;
    logic [RW-1:0] rd_done = '0;
    while (!bus.in_ready && waited < 50) begin
      cyc(1'b0, 32'h0, '0, 1'b0, 1'b0);
      waited++;
    end
    chk("vec_ready", bus.in_ready, 1);
    for (int c = 0; c <= v.w + 36; c++) begin
      cyc(c == 0, v.data, v.rd, c == v.w, 1'b0);
      if (wr_en) begin
        if (first < 0) first = c;
        nwr++;
      end
      if (wr_next_en) nnx++;
      if (c >= v.w + 1 && c <= v.w + 32) begin
        s[c - v.w - 1]  = data_rd;
        ns[c - v.w - 1] = data_rd_next;
      end
      if (done) begin
        ndone++;
        done_c  = c;
        rd_done = rd;
      end
    end
    $display("vec %0d: data=0x%08h rd=x%0d bit0@+%0d lat=%0d wr=%0d done@%0d",
             idx, v.data, v.rd, v.w, first, nwr, done_c);
    chk("vec_latency", 64'(first), 64'(v.exp_lat));
    chk("vec_wr_cnt", 64'(nwr), 64'(v.exp_wr));
    chk("vec_nxt_cnt", 64'(nnx), 64'(v.exp_nxt));
    chk("vec_done_cycle", 64'(done_c), 64'(v.exp_done_c));
    chk("vec_done_cnt", 64'(ndone), 1);
    chk("vec_rd", rd_done, v.rd);
    if (v.exp_wr > 0) begin
      chk("vec_stream", s, v.exp_stream);
      chk("vec_next_stream", ns, v.exp_nstream);
    end
  endtask

  // Random-test reference: pending word waits for bit0; active write is a start timestamp.
  bit          pend, act, hold;
  logic [31:0] pend_word, act_word, pd;
  logic [RW-1:0] pend_rd, act_rd, last_rd, pr;
  int          act_start, t, ph;

  initial begin
    logic [31:0] s1, s2;
    int          first2;
    vec_t        vx;

    vecs[0] = '{32'h8000_0001, 4'd5, 3, 4, 32, 31, 32'h8000_0001, 32'h4000_0000, 35};
    vecs[1] = '{32'hDEAD_BEEF, 4'd3, 1, 2, 32, 31, 32'hDEAD_BEEF, 32'h6F56_DF77, 33};
    vecs[2] = '{32'h1234_5678, 4'd7, 6, 7, 32, 31, 32'h1234_5678, 32'h091A_2B3C, 38};
`ifdef NANOV_REG_WRITER_X0_DROP_EN
    vecs[3] = '{32'hFFFF_FFFF, 4'd0, 2, -1, 0, 0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34};
`else
    vecs[3] = '{32'hFFFF_FFFF, 4'd0, 2, 3, 32, 31, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34};
`endif

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_rd    = '0;
    bit0         = 1'b0;
    rst          = 1'b1;

    // Reset
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_next_en", wr_next_en, 0);
    chk("reset_done", done, 0);
    chk("reset_read_through", read_through, 0);
    chk("reset_rd", rd, 0);
    $display("reset: in_ready=%0b busy=%0b", bus.in_ready, busy);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Back-to-back: second word offered in the done cycle
    s1 = '0; s2 = '0; first2 = -1;
    for (int c = 0; c <= 70; c++) begin
      cyc((c == 0) || (c == 33), (c == 0) ? 32'hDEAD_BEEF : 32'h1234_5678,
          (c == 0) ? 4'd3 : 4'd7, (c == 1) || (c == 34), 1'b0);
      if (c >= 2 && c <= 33) s1[c - 2] = data_rd;
      if (c >= 35 && c <= 66) s2[c - 35] = data_rd;
      if (c > 33 && wr_en && first2 < 0) first2 = c;
      if (c == 33) begin
        chk("b2b_ready_at_done", bus.in_ready, 1);
        chk("b2b_done", done, 1);
      end
      if (c == 34) begin
        chk("b2b_armed_wr_en", wr_en, 0);
        chk("b2b_armed_ready", bus.in_ready, 0);
        chk("b2b_new_rd", rd, 7);
      end
      if (c == 66) chk("b2b_done2", done, 1);
    end
    chk("b2b_stream1", s1, 32'hDEAD_BEEF);
    chk("b2b_stream2", s2, 32'h1234_5678);
    chk("b2b_start2", 64'(first2), 35);
    $display("b2b: x3=0x%08h x7=0x%08h second start @%0d", s1, s2, first2);

    // Backpressure: second word held from k=10
    s1 = '0; s2 = '0;
    for (int c = 0; c <= 70; c++) begin
      cyc((c == 0) || (c >= 12 && c <= 33), (c == 0) ? 32'hCAFE_0123 : 32'h0F0F_A5A5,
          (c == 0) ? 4'd2 : 4'd11, (c == 1) || (c == 34), 1'b0);
      if (c >= 2 && c <= 33) s1[c - 2] = data_rd;
      if (c >= 35 && c <= 66) s2[c - 35] = data_rd;
      if (c == 12) chk("bp_ready_k10", bus.in_ready, 0);
      if (c == 33) begin
        chk("bp_rd_held", rd, 2);
        chk("bp_ready_k31", bus.in_ready, 1);
      end
      if (c == 34) chk("bp_rd_latched", rd, 11);
    end
    chk("bp_stream_a", s1, 32'hCAFE_0123);
    chk("bp_stream_b", s2, 32'h0F0F_A5A5);
    $display("backpressure: a=0x%08h b=0x%08h", s1, s2);

    // Reset in the middle of a write
    for (int c = 0; c <= 15; c++) begin
      cyc(c == 0, 32'h5555_AAAA, 4'd9, c == 1, c == 14);
      if (c == 13) chk("mrst_wr_before", wr_en, 1);
      if (c == 15) begin
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", bus.in_ready, 1);
      end
    end
    $display("mid-shift reset: busy=%0b in_ready=%0b", busy, bus.in_ready);
    vx = '{32'hA5A5_0F0F, 4'd1, 2, 3, 32, 31, 32'hA5A5_0F0F, 32'h52D2_8787, 34};
    run_vec(4, vx);

    // Random traffic against the reference model
    pend = 0; act = 0; hold = 0; last_rd = '0; t = 0; act_start = 0;
    pend_word = '0; pend_rd = '0; act_word = '0; act_rd = '0; pd = '0; pr = '0;
    ph = $urandom_range(0, 31);
    for (int i = 0; i < 3000; i++) begin
      logic b, rs, e_ready;
      int   k;
      logic [11:0] e, a;
      b  = (ph == 0);
      ph = (ph + 1) % 32;
      rs = (i == 0) || ($urandom_range(0, 299) == 0);
      if (!hold && $urandom_range(0, 3) == 0) begin
        hold = 1;
        pd   = $urandom;
        pr   = RW'($urandom_range(0, 15));
      end
      cyc(hold, pd, pr, b, rs);
      k = t - act_start;
      e_ready = !pend && (!act || k == 31);
      if (i > 0) begin
        e = {e_ready, pend || act,
             act && !drop_rd(act_rd),
             act && k < 31 && !drop_rd(act_rd),
             act ? act_word[k] : 1'b0,
             (act && k < 31) ? act_word[k + 1] : 1'b0,
             act && !drop_rd(act_rd),
             act && k == 31,
             last_rd};
        a = {bus.in_ready, busy, wr_en, wr_next_en, data_rd, data_rd_next,
             read_through, done, rd};
        chk("rand_cycle", a, e);
      end
      if (rs) begin
        pend = 0; act = 0; last_rd = '0;
      end else begin
        if (act && k == 31) act = 0;
        if (pend && b) begin
          act = 1; act_start = t + 1; act_word = pend_word; act_rd = pend_rd; pend = 0;
        end
        if (hold && e_ready) begin
          pend = 1; pend_word = pd; pend_rd = pr; last_rd = pr; hold = 0;
          $display("rand accept @%0d: data=0x%08h rd=x%0d", i, pd, pr);
        end
      end
      t++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
